vfxp_round_wb: RTL and testbench

Writeback stage directly downstream of the vector add/min/max/averaging unit. Applies RVV fixed-point rounding (vxrm) to averaging results using the unit's per-element `vd`/`vd1` guard bits and passes mask and arithmetic results through unchanged. Buffers results in a small FIFO toward the VRF write port, because the upstream pipeline cannot stall. Reports free capacity to issue so it can throttle.

---
 rtl/vfxp_round_wb_pkg.sv | 25 ++
 rtl/vfxp_round_wb_fxp_round_lane.sv | 29 ++
 rtl/vfxp_round_wb.sv | 105 ++++++++++
 tb/tb_vfxp_round_wb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vfxp_round_wb_pkg.sv
// vfxp_round_wb_pkg: shared vALU encodings and the fixed-point rounding increment
package vfxp_round_wb_pkg;

    typedef enum logic [1:0] {
        VXRM_RNU = 2'd0,
        VXRM_RNE = 2'd1,
        VXRM_RDN = 2'd2,
        VXRM_ROD = 2'd3
    } vxrm_e;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    // Rounding increment for a one-bit right shift: vd is the new LSB, vd1 the bit shifted out.
    function automatic logic rnd_inc(input logic [1:0] vxrm, input logic vd, input logic vd1);
        return (vxrm == VXRM_RNU) ? vd1 :
               (vxrm == VXRM_RNE) ? (vd1 & vd) :
               (vxrm == VXRM_ROD) ? (vd1 & ~vd) : 1'b0;
    endfunction

endpackage

// File: rtl/vfxp_round_wb_fxp_round_lane.sv
// fxp_round_lane: per-element rounding of a result vector, one segmented incrementer per SEW
module fxp_round_lane
    import vfxp_round_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]   vec,
    input  logic [DATA_WIDTH/8-1:0] vd,
    input  logic [DATA_WIDTH/8-1:0] vd1,
    input  logic [1:0]              sew,
    input  logic [1:0]              vxrm,
    output logic [DATA_WIDTH-1:0]   rounded
);

    logic [DATA_WIDTH-1:0] seg [4];

    // Each element adds its own increment, so carries stay inside the element.
    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int EW = 8 << s;
        localparam int NE = DATA_WIDTH / EW;
        for (genvar e = 0; e < NE; e++) begin : g_el
            assign seg[s][e*EW +: EW] = vec[e*EW +: EW]
                + EW'(rnd_inc(vxrm, vd[e*EW/8], vd1[e*EW/8]));
        end
    end

    assign rounded = seg[sew];

endmodule

// File: rtl/vfxp_round_wb.sv
// vfxp_round_wb: rounds averaging results and buffers all results toward the VRF write port
module vfxp_round_wb
    import vfxp_round_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_vec,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [BE_WIDTH-1:0]           in_be,
    input  logic                          in_mask,
    input  logic                          in_fxp,
    input  logic [BE_WIDTH-1:0]           in_vd,
    input  logic [BE_WIDTH-1:0]           in_vd1,
    input  logic [1:0]                    in_sew,
    input  logic [1:0]                    in_vxrm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_vec,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [BE_WIDTH-1:0]           out_be,
    output logic                          out_mask,
    output logic [$clog2(FIFO_DEPTH):0]   out_free,
    output logic                          err_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] rounded, r_vec;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BE_WIDTH-1:0]   r_be;
    logic                  r_mask, r_valid;

    logic [DATA_WIDTH-1:0] mem_vec  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [BE_WIDTH-1:0]   mem_be   [FIFO_DEPTH];
    logic                  mem_mask [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           used;
    logic                  push, pop;

    fxp_round_lane #(.DATA_WIDTH(DATA_WIDTH)) u_round (
        .vec     (in_vec),
        .vd      (in_vd),
        .vd1     (in_vd1),
        .sew     (in_sew),
        .vxrm    (in_vxrm),
        .rounded (rounded)
    );

    // Stage R: capture every beat unconditionally; rounding is skipped for the illegal fxp+mask case.
    always_ff @(posedge clk) begin
        r_valid <= rst ? 1'b0 : in_valid;
        if (in_valid) begin
            r_vec  <= (in_fxp && !in_mask) ? rounded : in_vec;
            r_addr <= in_addr;
            r_be   <= in_be;
            r_mask <= in_mask;
        end
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = r_valid && ((count < CW'(FIFO_DEPTH)) || pop);
    assign used      = {1'b0, count} + (CW+1)'(r_valid);
    assign out_free  = (used > (CW+1)'(FIFO_DEPTH)) ? '0 : CW'((CW+1)'(FIFO_DEPTH) - used);

    assign out_vec   = out_valid ? mem_vec[rd_ptr]  : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
    assign out_be    = out_valid ? mem_be[rd_ptr]   : '0;
    assign out_mask  = out_valid ? mem_mask[rd_ptr] : 1'b0;

    // FIFO storage: written only on push, so the head stays put while the VRF is not ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_vec[wr_ptr]  <= r_vec;
            mem_addr[wr_ptr] <= r_addr;
            mem_be[wr_ptr]   <= r_be;
            mem_mask[wr_ptr] <= r_mask;
        end
    end

    // FIFO control: pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(push);
            rd_ptr       <= rd_ptr + PW'(pop);
            count        <= count + CW'(push) - CW'(pop);
            err_overflow <= err_overflow || (r_valid && !push);
        end
    end

endmodule

// File: tb/tb_vfxp_round_wb.sv
// tb_vfxp_round_wb: directed vector table for rounding plus FIFO overflow, wrap and reset sequences
module tb_vfxp_round_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_vec;
    logic [31:0] in_addr;
    logic [7:0]  in_be;
    logic        in_mask;
    logic        in_fxp;
    logic [7:0]  in_vd;
    logic [7:0]  in_vd1;
    logic [1:0]  in_sew;
    logic [1:0]  in_vxrm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vec;
    logic [31:0] out_addr;
    logic [7:0]  out_be;
    logic        out_mask;
    logic [2:0]  out_free;
    logic        err_overflow;

    int n_chk = 0;
    int n_fail = 0;

    vfxp_round_wb dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_vec       (in_vec),
        .in_addr      (in_addr),
        .in_be        (in_be),
        .in_mask      (in_mask),
        .in_fxp       (in_fxp),
        .in_vd        (in_vd),
        .in_vd1       (in_vd1),
        .in_sew       (in_sew),
        .in_vxrm      (in_vxrm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec),
        .out_addr     (out_addr),
        .out_be       (out_be),
        .out_mask     (out_mask),
        .out_free     (out_free),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sew;
        logic [1:0]  vxrm;
        logic        fxp;
        logic        mask;
        logic [63:0] vec;
        logic [7:0]  vd;
        logic [7:0]  vd1;
        logic [7:0]  be;
        logic [63:0] exp;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds one beat for one cycle.
    task automatic beat(input logic [31:0] addr, input logic fxp, input logic mask, input logic [63:0] v);
        in_valid = 1'b1;
        in_addr  = addr;
        in_fxp   = fxp;
        in_mask  = mask;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tv[0]  = '{2'd0, 2'd0, 1'b1, 1'b0, 64'h7F, 8'h01, 8'h01, 8'h01, 64'h80};
        tv[1]  = '{2'd0, 2'd1, 1'b1, 1'b0, 64'h7F, 8'h01, 8'h01, 8'h01, 64'h80};
        tv[2]  = '{2'd0, 2'd2, 1'b1, 1'b0, 64'h7F, 8'h01, 8'h01, 8'h01, 64'h7F};
        tv[3]  = '{2'd0, 2'd3, 1'b1, 1'b0, 64'h7F, 8'h01, 8'h01, 8'h01, 64'h7F};
        tv[4]  = '{2'd0, 2'd1, 1'b1, 1'b0, 64'h7F, 8'h00, 8'h01, 8'h01, 64'h7F};
        tv[5]  = '{2'd0, 2'd3, 1'b1, 1'b0, 64'h7F, 8'h00, 8'h01, 8'h01, 64'h80};
        tv[6]  = '{2'd1, 2'd0, 1'b1, 1'b0, 64'h0000_0000_0000_FFFF, 8'h00, 8'h01, 8'hFF, 64'h0};
        tv[7]  = '{2'd2, 2'd0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 8'h00, 8'h01, 8'hFF, 64'h0};
        tv[8]  = '{2'd3, 2'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h01, 8'hFF, 64'h0};
        tv[9]  = '{2'd0, 2'd0, 1'b0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, 8'hFF, 8'h3C, 64'hA5A5_A5A5_A5A5_A5A5};
        tv[10] = '{2'd0, 2'd0, 1'b1, 1'b1, 64'h7F, 8'h00, 8'hFF, 8'h0F, 64'h7F};
        tv[11] = '{2'd0, 2'd0, 1'b1, 1'b0, 64'h00FF_7F01_0203_0405, 8'h00, 8'hFF, 8'hFF, 64'h0100_8002_0304_0506};
        tv[12] = '{2'd1, 2'd0, 1'b1, 1'b0, 64'h0001_0002_0003_0004, 8'h00, 8'hAA, 8'hFF, 64'h0001_0002_0003_0004};
        tv[13] = '{2'd1, 2'd0, 1'b1, 1'b0, 64'h0001_0002_0003_0004, 8'h00, 8'h05, 8'hFF, 64'h0001_0002_0004_0005};
        tv[14] = '{2'd2, 2'd3, 1'b1, 1'b0, 64'h0000_0010_0000_0020, 8'h10, 8'h11, 8'hF0, 64'h0000_0010_0000_0021};

        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_addr = '0; in_be = '0; in_mask = 1'b0;
        in_fxp = 1'b0; in_vd = '0; in_vd1 = '0; in_sew = '0; in_vxrm = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_vec", out_vec, 64'd0);
        chk("reset_addr", 64'(out_addr), 64'd0);
        chk("reset_free", 64'(out_free), 64'd4);
        chk("reset_err", 64'(err_overflow), 64'd0);

        for (int i = 0; i < 15; i++) begin
            in_sew = tv[i].sew; in_vxrm = tv[i].vxrm; in_vd = tv[i].vd; in_vd1 = tv[i].vd1; in_be = tv[i].be;
            beat(32'(100 + i), tv[i].fxp, tv[i].mask, tv[i].vec);
            chk($sformatf("v%0d_early_valid", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_vec", i), out_vec, tv[i].exp);
            chk($sformatf("v%0d_addr", i), 64'(out_addr), 64'(100 + i));
            chk($sformatf("v%0d_be", i), 64'(out_be), 64'(tv[i].be));
            chk($sformatf("v%0d_mask", i), 64'(out_mask), 64'(tv[i].mask));
        end
        in_be = 8'hFF;
        @(negedge clk);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) beat(32'(k), 1'b0, 1'b0, 64'(k));
        repeat (3) @(negedge clk);
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_free_full", 64'(out_free), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("drain%0d_addr", k), 64'(out_addr), 64'(k));
            @(negedge clk);
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        chk("drain_free", 64'(out_free), 64'd4);
        chk("drain_err_sticky", 64'(err_overflow), 64'd1);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) beat(32'(30 + k), 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("pre_rst_free", 64'(out_free), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_free", 64'(out_free), 64'd4);
        chk("mid_rst_err", 64'(err_overflow), 64'd0);
        out_ready = 1'b1;
        beat(32'd40, 1'b0, 1'b0, 64'h1234);
        chk("post_rst_r_free", 64'(out_free), 64'd3);
        chk("post_rst_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_addr", 64'(out_addr), 64'd40);
        chk("post_rst_vec", out_vec, 64'h1234);
        @(negedge clk);

        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) beat(32'(10 + k), 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        chk("full_free", 64'(out_free), 64'd0);
        in_valid = 1'b1; in_addr = 32'd14;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            chk($sformatf("wrap%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("wrap%0d_addr", k), 64'(out_addr), 64'(10 + k));
            if (k <= 6) chk($sformatf("wrap%0d_free", k), 64'(out_free), 64'd0);
            in_valid = (15 + k) <= 21;
            in_addr  = 32'(15 + k);
        end
        @(negedge clk);
        chk("wrap_empty", 64'(out_valid), 64'd0);
        chk("wrap_no_drop", 64'(err_overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
